// File: rtl/keynsham_dma_engine_if.sv
// Peripheral-bus link used for both the DMA config port (responder side)
// and its copy port (initiator side).
interface keynsham_dma_engine_if;
  logic        access;
  logic        cs;
  logic [29:0] addr;
  logic [31:0] wr_val;
  logic        wr_en;
  logic [3:0]  bytesel;
  logic        error;
  logic        ack;
  logic [31:0] data;

  modport master (
    output access, addr, wr_val, wr_en, bytesel,
    input  ack, error, data
  );

  modport slave (
    input  access, addr, wr_val, wr_en, bytesel,
    output cs, ack, error, data
  );
endinterface

// File: rtl/keynsham_dma_engine.sv
// Single-channel word-copy DMA: config registers on a responder port,
// copies LEN words SRC->DST as a bus initiator, level irq on done/fault.
module keynsham_dma_engine #(
  parameter logic [31:0] bus_address    = 32'h0,
  parameter logic [31:0] bus_size       = 32'h0,
  parameter int unsigned timeout_cycles = 256,
  parameter int unsigned len_bits       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  keynsham_dma_engine_if.slave  bus,
  keynsham_dma_engine_if.master m,
  output logic                 irq
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_GAP_W, S_WR, S_GAP_R, S_FIN} state_t;

  localparam int unsigned TW = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(timeout_cycles - 1);

  state_t              state, state_nx;
  logic [29:0]         src, dst;
  logic [len_bits-1:0] len;
  logic                done, err, irqen;
  logic [31:0]         hold;
  logic [TW-1:0]       tmo_cnt;
  logic                ack_q;
  logic [31:0]         rdata_q;
  logic [32:0]         byte_addr, win_lo, win_hi;
  logic                hit, cfg_wr, cfg_rd, busy, start, in_acc, tmo, fault, acc_ok;
  logic [1:0]          reg_sel;
  logic [31:0]         rd_mux;
  logic                unused_bits;

  assign byte_addr = {1'b0, bus.addr, 2'b00};
  assign win_lo    = {1'b0, bus_address};
  assign win_hi    = win_lo + {1'b0, bus_size};
  assign bus.cs    = (byte_addr >= win_lo) && (byte_addr < win_hi);

  // ack_q masks a held strobe so each access is acknowledged exactly once
  assign hit     = bus.access & bus.cs & ~ack_q;
  assign cfg_wr  = hit & bus.wr_en;
  assign cfg_rd  = hit & ~bus.wr_en;
  assign reg_sel = bus.addr[1:0];
  assign busy    = (state != S_IDLE);
  assign start   = cfg_wr && (reg_sel == 2'd3) && bus.wr_val[0] && !busy;

  assign in_acc = (state == S_RD) || (state == S_WR);
  assign tmo    = (tmo_cnt == TMO_LAST);
  assign fault  = in_acc & (m.error | (~m.ack & tmo));
  assign acc_ok = in_acc & m.ack & ~m.error;

  assign bus.ack     = ack_q;
  assign bus.data    = rdata_q;
  assign bus.error   = 1'b0;
  assign m.bytesel   = '1;
  assign irq         = irqen & (done | err);
  assign unused_bits = &{1'b0, bus.bytesel, bus.wr_val};

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = (len == '0) ? S_FIN : S_RD;
      S_RD:    if (fault) state_nx = S_IDLE;
               else if (acc_ok) state_nx = S_GAP_W;
      S_GAP_W: state_nx = S_WR;
      S_WR:    if (fault) state_nx = S_IDLE;
               else if (acc_ok) state_nx = (len == len_bits'(1)) ? S_IDLE : S_GAP_R;
      S_GAP_R: state_nx = S_RD;
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    m.access = 1'b0;
    m.wr_en  = 1'b0;
    m.addr   = '0;
    m.wr_val = '0;
    unique case (state)
      S_RD: begin
        m.access = 1'b1;
        m.addr   = src;
      end
      S_WR: begin
        m.access = 1'b1;
        m.wr_en  = 1'b1;
        m.addr   = dst;
        m.wr_val = hold;
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    unique case (reg_sel)
      2'd0: rd_mux = {2'b00, src};
      2'd1: rd_mux = {2'b00, dst};
      2'd2: rd_mux = 32'(len);
      2'd3: rd_mux = {27'd0, irqen, err, done, busy, 1'b0};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
      src     <= '0;
      dst     <= '0;
      len     <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      irqen   <= 1'b0;
      hold    <= '0;
      tmo_cnt <= '0;
    end else begin
      ack_q   <= hit;
      rdata_q <= cfg_rd ? rd_mux : '0;

      if (cfg_wr) begin
        unique case (reg_sel)
          2'd0: if (!busy) src <= bus.wr_val[29:0];
          2'd1: if (!busy) dst <= bus.wr_val[29:0];
          2'd2: if (!busy) len <= bus.wr_val[len_bits-1:0];
          default: begin
            irqen <= bus.wr_val[4];
            if (bus.wr_val[2] || start) done <= 1'b0;
            if (bus.wr_val[3] || start) err  <= 1'b0;
          end
        endcase
      end

      if (in_acc) tmo_cnt <= tmo_cnt + 1'b1;
      else        tmo_cnt <= '0;

      // transfer events are applied last so they win over a same-cycle W1C
      if (fault) begin
        err  <= 1'b1;
        done <= 1'b0;
      end else if (acc_ok) begin
        if (state == S_RD) begin
          hold <= m.data;
        end else begin
          src <= src + 30'd1;
          dst <= dst + 30'd1;
          len <= len - 1'b1;
          if (len == len_bits'(1)) done <= 1'b1;
        end
      end

      if (state == S_FIN) done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_keynsham_dma_engine.sv
// Scoreboard bench for keynsham_dma_engine: config reads and initiator
// accesses are queued as expectations and checked by independent monitors.
module tb_keynsham_dma_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq;

  always #5 clk = ~clk;

  keynsham_dma_engine_if bus_if ();
  keynsham_dma_engine_if m_if ();

  keynsham_dma_engine #(
    .bus_address   (32'h0000_1000),
    .bus_size      (32'h0000_0010),
    .timeout_cycles(256),
    .len_bits      (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if),
    .m   (m_if),
    .irq (irq)
  );

  typedef struct {
    logic        wr;
    logic [29:0] addr;
    logic [31:0] data;
    int unsigned gap;
    int unsigned dur;
  } acc_t;

  typedef struct {
    string       name;
    logic [31:0] val;
  } rd_t;

  acc_t exp_acc[$];
  rd_t  exp_rd[$];
  int   checks   = 0;
  int   failures = 0;

  logic        rd_pending = 1'b0;
  int unsigned err_write  = 0;
  int unsigned wr_idx     = 0;
  logic        noack      = 1'b0;

  function automatic logic [31:0] pat(input logic [29:0] a);
    return {2'b00, a} ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic push_acc(input logic wr, input logic [29:0] a, input int unsigned gap,
                          input int unsigned dur);
    acc_t e;
    e.wr   = wr;
    e.addr = a;
    e.data = wr ? pat(a - 30'h100) : 32'h0;
    e.gap  = gap;
    e.dur  = dur;
    exp_acc.push_back(e);
  endtask

  task automatic cfg_xfer(input logic wr, input logic [1:0] sel, input logic [31:0] val);
    @(negedge clk);
    bus_if.access  = 1'b1;
    bus_if.wr_en   = wr;
    bus_if.addr    = {28'h100, sel};
    bus_if.wr_val  = val;
    bus_if.bytesel = 4'hF;
    @(negedge clk);
    check("cfg_ack", {31'd0, bus_if.ack}, 32'd1);
    bus_if.access = 1'b0;
    bus_if.wr_en  = 1'b0;
    bus_if.wr_val = '0;
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [31:0] val);
    cfg_xfer(1'b1, sel, val);
  endtask

  task automatic cfg_read(input string name, input logic [1:0] sel, input logic [31:0] val);
    rd_t e;
    e.name = name;
    e.val  = val;
    exp_rd.push_back(e);
    rd_pending = 1'b1;
    cfg_xfer(1'b0, sel, 32'h0);
  endtask

  // config read monitor
  initial begin
    rd_t e;
    forever begin
      @(negedge clk);
      if (bus_if.ack && rd_pending) begin
        rd_pending = 1'b0;
        if (exp_rd.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL cfg_rd_unexpected: got %h want none", bus_if.data);
        end else begin
          e = exp_rd.pop_front();
          check(e.name, bus_if.data, e.val);
        end
      end
    end
  end

  // initiator monitor plus 1-wait responder model
  initial begin
    acc_t        cur;
    logic        prev_acc  = 1'b0;
    logic        prev_done = 1'b0;
    int unsigned cyc = 0, last_start = 0, dur_cnt = 0, rcyc = 0;
    cur.dur = 0;
    cur.gap = 0;
    m_if.cs    = 1'b1;
    m_if.ack   = 1'b0;
    m_if.error = 1'b0;
    m_if.data  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (prev_done) check("m_drop_after_ack", {31'd0, m_if.access}, 32'd0);
      if (m_if.access && !prev_acc) begin
        if (m_if.wr_en) wr_idx++;
        if (exp_acc.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL m_unexpected_access: got addr %h wr %b want none", m_if.addr, m_if.wr_en);
          cur.dur = 0;
        end else begin
          cur = exp_acc.pop_front();
          check("m_op", {1'b0, m_if.wr_en, m_if.addr}, {1'b0, cur.wr, cur.addr});
          if (cur.wr) check("m_wr_val", m_if.wr_val, cur.data);
          if (cur.gap != 0) check("m_gap", cyc - last_start, cur.gap);
        end
        last_start = cyc;
        dur_cnt    = 0;
        rcyc       = 0;
      end
      if (!m_if.access && prev_acc && cur.dur != 0) check("m_dur", dur_cnt, cur.dur);
      if (m_if.access) begin
        dur_cnt++;
        rcyc++;
      end
      m_if.error = m_if.access && m_if.wr_en && (wr_idx == err_write) && (rcyc == 2);
      m_if.ack   = m_if.access && !noack && (rcyc == 2) && !m_if.error;
      m_if.data  = (m_if.ack && !m_if.wr_en) ? pat(m_if.addr) : 32'h0;
      prev_acc   = m_if.access;
      prev_done  = m_if.ack | m_if.error;
    end
  end

  initial begin
    bus_if.access  = 1'b0;
    bus_if.wr_en   = 1'b0;
    bus_if.addr    = '0;
    bus_if.wr_val  = '0;
    bus_if.bytesel = '0;

    repeat (3) @(negedge clk);
    check("rst_m_access", {31'd0, m_if.access}, 32'd0);
    check("rst_bus_ack", {31'd0, bus_if.ack}, 32'd0);
    check("rst_bus_data", bus_if.data, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    rst = 1'b0;
    cfg_read("rst_src", 2'd0, 32'h0);
    cfg_read("rst_dst", 2'd1, 32'h0);
    cfg_read("rst_len", 2'd2, 32'h0);
    cfg_read("rst_ctrl", 2'd3, 32'h0);

    // 3-word copy with LEN/START rewrites while busy
    cfg_write(2'd0, 32'h100);
    cfg_write(2'd1, 32'h200);
    cfg_write(2'd2, 32'd3);
    push_acc(1'b0, 30'h100, 0, 2);
    push_acc(1'b1, 30'h200, 3, 2);
    push_acc(1'b0, 30'h101, 3, 2);
    push_acc(1'b1, 30'h201, 3, 2);
    push_acc(1'b0, 30'h102, 3, 2);
    push_acc(1'b1, 30'h202, 3, 2);
    cfg_write(2'd3, 32'h1);
    repeat (4) @(negedge clk);
    cfg_write(2'd2, 32'd9);
    cfg_write(2'd3, 32'h1);
    repeat (30) @(negedge clk);
    cfg_read("t1_ctrl", 2'd3, 32'h4);
    cfg_read("t1_len", 2'd2, 32'h0);
    cfg_read("t1_src", 2'd0, 32'h103);
    cfg_read("t1_dst", 2'd1, 32'h203);
    check("t1_irq", {31'd0, irq}, 32'd0);

    // LEN=0: no traffic, DONE one cycle after the ack
    cfg_write(2'd3, 32'h1C);
    check("t2_irq_cleared", {31'd0, irq}, 32'd0);
    cfg_write(2'd2, 32'd0);
    cfg_write(2'd3, 32'h11);
    check("t2_irq_ack_cycle", {31'd0, irq}, 32'd0);
    @(negedge clk);
    check("t2_irq_next_cycle", {31'd0, irq}, 32'd1);
    cfg_read("t2_ctrl", 2'd3, 32'h14);
    repeat (10) @(negedge clk);

    // error on the 2nd write of a 4-word copy
    cfg_write(2'd3, 32'h1C);
    wr_idx    = 0;
    err_write = 2;
    cfg_write(2'd0, 32'h300);
    cfg_write(2'd1, 32'h400);
    cfg_write(2'd2, 32'd4);
    push_acc(1'b0, 30'h300, 0, 2);
    push_acc(1'b1, 30'h400, 3, 2);
    push_acc(1'b0, 30'h301, 3, 2);
    push_acc(1'b1, 30'h401, 3, 2);
    cfg_write(2'd3, 32'h11);
    repeat (30) @(negedge clk);
    cfg_read("t3_ctrl", 2'd3, 32'h18);
    cfg_read("t3_dst", 2'd1, 32'h401);
    cfg_read("t3_len", 2'd2, 32'd3);
    cfg_read("t3_src", 2'd0, 32'h301);
    check("t3_irq", {31'd0, irq}, 32'd1);
    cfg_write(2'd3, 32'h18);
    check("t3_irq_w1c", {31'd0, irq}, 32'd0);
    err_write = 0;

    // responder never acks: 256-cycle timeout
    noack = 1'b1;
    cfg_write(2'd0, 32'h500);
    cfg_write(2'd2, 32'd1);
    push_acc(1'b0, 30'h500, 0, 256);
    cfg_write(2'd3, 32'h11);
    repeat (270) @(negedge clk);
    cfg_read("t4_ctrl", 2'd3, 32'h18);
    cfg_read("t4_len", 2'd2, 32'd1);
    cfg_read("t4_src", 2'd0, 32'h500);
    check("t4_irq", {31'd0, irq}, 32'd1);

    // reset in the middle of a read access
    cfg_write(2'd3, 32'h18);
    cfg_write(2'd0, 32'h600);
    cfg_write(2'd2, 32'd2);
    push_acc(1'b0, 30'h600, 0, 0);
    cfg_write(2'd3, 32'h1);
    repeat (4) @(negedge clk);
    check("t5_access_before_rst", {31'd0, m_if.access}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t5_access_after_rst", {31'd0, m_if.access}, 32'd0);
    rst   = 1'b0;
    noack = 1'b0;
    cfg_read("t5_src", 2'd0, 32'h0);
    cfg_read("t5_dst", 2'd1, 32'h0);
    cfg_read("t5_len", 2'd2, 32'h0);
    cfg_read("t5_ctrl", 2'd3, 32'h0);
    check("t5_irq", {31'd0, irq}, 32'd0);

    repeat (5) @(negedge clk);
    check("acc_queue_empty", exp_acc.size(), 32'd0);
    check("rd_queue_empty", exp_rd.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL tb_timeout: got no finish want finish");
    $fatal(1);
  end

endmodule
